des_round_ctrl: RTL
===================

# des_round_ctrl

Iterative DES datapath controller that sits directly downstream of the round-key generator. It consumes the sixteen 48-bit round keys and processes one 64-bit block, encrypt or decrypt, at one round per clock. The Feistel round function (E-expansion, S-boxes, P) is an external combinational block: this block drives its R half and round-key inputs and registers its 32-bit result. The block applies the initial and final permutations, sequences the 16 rounds with a counter and state machine, and handshakes blocks in and out with valid/ready.

## Interface
Parameters: none.
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  in_block / in_decrypt are valid
- in_ready  out  1  block can accept; high only in IDLE
- in_block  in  64  plaintext (encrypt) or ciphertext (decrypt); FIPS 46-3 bit 1 = in_block[63]
- in_decrypt  in  1  0 = encrypt, 1 = decrypt; sampled at acceptance
- r_key1 … r_key16  in  48 each  round keys from the key generator; must stay stable from acceptance to output handshake
- f_r_out  out  32  current R half to the round function
- f_key_out  out  48  round key selected for the current round
- f_in  in  32  round-function result f(f_r_out, f_key_out), combinational
- out_valid  out  1  out_block is valid
- out_ready  in  1  downstream accepts out_block
- out_block  out  64  result after final permutation; FIPS bit 1 = out_block[63]

## Operation
- States: IDLE, ROUND, DONE. Registers: L[31:0], R[31:0], cnt[3:0], dec, out_block.
- IDLE: in_ready = 1. On in_valid && in_ready: {L,R} <= IP(in_block) (standard DES IP), cnt <= 0, dec <= in_decrypt, go to ROUND.
- ROUND: each cycle L <= R, R <= L ^ f_in, cnt <= cnt + 1. f_r_out = R.
- Key select: encrypt uses r_key(cnt+1); decrypt uses r_key(16-cnt). f_key_out is combinational from cnt and dec and is also driven, without being meaningful, in IDLE and DONE.
- On the round with cnt = 15, instead of writing L/R, out_block <= FP({L ^ f_in, R}), i.e. the preoutput with the final swap applied (standard DES FP). Go to DONE. cnt wraps to 0.
- DONE: out_valid = 1, out_block held. On out_ready, go to IDLE, and out_valid drops the next cycle. in_valid is ignored outside IDLE, and f_in is ignored outside ROUND.
- Reset, any time including mid-round: state IDLE, L = R = 0, cnt = 0, dec = 0, out_block = 0, out_valid = 0, in_ready = 1. An in-flight block is discarded with no output.

## Timing
- Acceptance at edge A. Rounds are performed at edges A+1 … A+16. out_block and out_valid update at edge A+16.
- Latency: out_valid is first high in the cycle after edge A+16, 16 cycles after acceptance.
- Minimum interval between acceptances: 18 cycles (16 rounds, 1 DONE cycle with out_ready high, 1 IDLE cycle).
- in_ready and out_valid are decoded from registered state, with no combinational path from in_valid or out_ready.
- f_r_out → f_in is a combinational loop through the external round function. It is timed as one single-cycle path.
- out_ready held low: DONE persists indefinitely and out_block is stable. No new block is accepted.

## Test plan
- Encrypt vector: key 133457799BBCDFF1 through key_gen, in_block 0123456789ABCDEF, in_decrypt 0 → out_block 85E813540F0AB405, with out_valid rising exactly 16 cycles after acceptance.
- Decrypt vector: same key, in_block 85E813540F0AB405, in_decrypt 1 → out_block 0123456789ABCDEF.
- Key order: distinct tagged round keys. Encrypt → f_key_out equals r_key1 … r_key16 on ROUND cycles 0…15. Decrypt → r_key16 … r_key1.
- Backpressure:
  - out_ready held low 5 cycles after out_valid → out_block unchanged, in_ready 0, a pulsed in_valid is not accepted.
  - After out_ready is raised → IDLE, and the next block is accepted no earlier than 2 cycles after the output handshake.
- Reset mid-operation: assert rst_n = 0 during round 7 → all outputs take reset values immediately. After release, a fresh block yields the correct result with full 16-cycle latency.
- Back-to-back: three blocks with in_valid held high and out_ready held high → three correct results, acceptances 18 cycles apart.

Source files
------------

// File: rtl/des_round_ctrl.sv
// Iterative DES round controller: applies IP/FP, sequences 16 Feistel rounds
// at one round per clock through an external round function, and exchanges
// blocks with valid/ready handshakes on both sides.
module des_round_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_block,
   input  logic        in_decrypt,
   input  logic [47:0] r_key1,
   input  logic [47:0] r_key2,
   input  logic [47:0] r_key3,
   input  logic [47:0] r_key4,
   input  logic [47:0] r_key5,
   input  logic [47:0] r_key6,
   input  logic [47:0] r_key7,
   input  logic [47:0] r_key8,
   input  logic [47:0] r_key9,
   input  logic [47:0] r_key10,
   input  logic [47:0] r_key11,
   input  logic [47:0] r_key12,
   input  logic [47:0] r_key13,
   input  logic [47:0] r_key14,
   input  logic [47:0] r_key15,
   input  logic [47:0] r_key16,
   output logic [31:0] f_r_out,
   output logic [47:0] f_key_out,
   input  logic [31:0] f_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_block
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRound = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [31:0] l_q, l_d;
   logic [31:0] r_q, r_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dec_q, dec_d;
   logic [63:0] out_block_q, out_block_d;
   logic [63:0] ip_block;
   logic [63:0] fp_block;
   logic [3:0]  key_idx;

   // DES initial permutation; FIPS bit k lives at vector index 64-k.
   // Row r of the IP table starts at 58+2r (rows 0-3) or 57+2(r-4) and steps down by 8.
   function automatic logic [63:0] des_ip(input logic [63:0] x);
      logic [63:0] y;
      int          src;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         src = (i < 32) ? (58 + 2 * (i / 8) - 8 * (i % 8))
                        : (57 + 2 * (i / 8 - 4) - 8 * (i % 8));
         y[6'(63 - i)] = x[6'(64 - src)];
      end
      return y;
   endfunction

   // Final permutation is the inverse of IP, so scatter through the same table.
   function automatic logic [63:0] des_fp(input logic [63:0] x);
      logic [63:0] y;
      int          src;
      y = '0;
      for (int i = 0; i < 64; i++) begin
         src = (i < 32) ? (58 + 2 * (i / 8) - 8 * (i % 8))
                        : (57 + 2 * (i / 8 - 4) - 8 * (i % 8));
         y[6'(64 - src)] = x[6'(63 - i)];
      end
      return y;
   endfunction

   assign ip_block = des_ip(in_block);
   // Preoutput with the final swap: R16 = L15 ^ f, L16 = R15.
   assign fp_block = des_fp({l_q ^ f_in, r_q});

   // Round-key select: encrypt walks keys 1..16, decrypt walks 16..1.
   always_comb begin
      key_idx   = dec_q ? (4'd15 - cnt_q) : cnt_q;
      f_key_out = r_key1;
      case (key_idx)
         4'd0:  f_key_out = r_key1;
         4'd1:  f_key_out = r_key2;
         4'd2:  f_key_out = r_key3;
         4'd3:  f_key_out = r_key4;
         4'd4:  f_key_out = r_key5;
         4'd5:  f_key_out = r_key6;
         4'd6:  f_key_out = r_key7;
         4'd7:  f_key_out = r_key8;
         4'd8:  f_key_out = r_key9;
         4'd9:  f_key_out = r_key10;
         4'd10: f_key_out = r_key11;
         4'd11: f_key_out = r_key12;
         4'd12: f_key_out = r_key13;
         4'd13: f_key_out = r_key14;
         4'd14: f_key_out = r_key15;
         4'd15: f_key_out = r_key16;
         default: f_key_out = r_key1;
      endcase
   end

   // Next-state logic for the sequencer and Feistel halves.
   always_comb begin
      state_d     = state_q;
      l_d         = l_q;
      r_d         = r_q;
      cnt_d       = cnt_q;
      dec_d       = dec_q;
      out_block_d = out_block_q;
      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               {l_d, r_d} = ip_block;
               cnt_d      = 4'd0;
               dec_d      = in_decrypt;
               state_d    = StRound;
            end
         end
         StRound: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
               // Last round goes straight to the output register; L/R are left as-is.
               out_block_d = fp_block;
               state_d     = StDone;
            end else begin
               l_d = r_q;
               r_d = l_q ^ f_in;
            end
         end
         StDone: begin
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with asynchronous reset; any in-flight block is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         l_q         <= '0;
         r_q         <= '0;
         cnt_q       <= '0;
         dec_q       <= 1'b0;
         out_block_q <= '0;
      end else begin
         state_q     <= state_d;
         l_q         <= l_d;
         r_q         <= r_d;
         cnt_q       <= cnt_d;
         dec_q       <= dec_d;
         out_block_q <= out_block_d;
      end
   end

   assign in_ready  = (state_q == StIdle);
   assign out_valid = (state_q == StDone);
   assign f_r_out   = r_q;
   assign out_block = out_block_q;

endmodule
